trena_uc: RTL
=============

# trena_uc

Control unit for the ultrasonic tape-measure datapath. On a request it:
- clears the ASCII digit counter;
- starts one HC-SR04 measurement and waits for it, with a timeout;
- sends the four-character frame (three BCD digits plus separator) through the 7E1 serial transmitter, one character at a time.

It drives the datapath's `zera`, `medir`, `partida_serial` and `conta_ascii` controls and consumes its status flags.

## Interface
- `TIMEOUT_CICLOS`, 2500000: cycles allowed in `aguarda_medida` before the measurement is declared failed (50 ms at 50 MHz).
- `INTERVALO_CICLOS`, 25000000: idle cycles between automatic measurements in continuous mode.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; forces `inicial`.
- `mensurar`  in  1  start request, one-cycle pulse from an upstream edge detector.
- `continuo`  in  1  continuous-mode select; used only when the macro is defined.
- `pronto_medida`  in  1  one-cycle pulse from the HC-SR04 interface: measurement valid.
- `pronto_transmissao`  in  1  one-cycle pulse from the serial transmitter: character finished.
- `fim_serial`  in  1  digit counter at its last position (separator character).
- `zera`  out  1  clears the digit counter.
- `medir`  out  1  one-cycle measurement start.
- `partida_serial`  out  1  one-cycle character transmit start.
- `conta_ascii`  out  1  one-cycle digit-counter advance.
- `pronto`  out  1  one-cycle frame-complete pulse.
- `erro`  out  1  high while in `erro`.
- `db_estado`  out  4  current state code.

## Operation
- Moore FSM. Outputs are decoded from the state register only. Codes:
  - inicial=0, preparacao=1, inicia_medida=2, aguarda_medida=3, transmite=4, aguarda_transmissao=5, proximo=6, final=7, espera_intervalo=8, erro=0xE.
- Transitions:
  - inicial → preparacao on `mensurar`.
  - preparacao (`zera`=1) → inicia_medida.
  - inicia_medida (`medir`=1) → aguarda_medida.
  - aguarda_medida: → transmite on `pronto_medida`; → erro when the cycle counter reaches `TIMEOUT_CICLOS`-1.
  - transmite (`partida_serial`=1) → aguarda_transmissao.
  - aguarda_transmissao: on `pronto_transmissao`, → final if `fim_serial`=1, otherwise → proximo.
  - proximo (`conta_ascii`=1) → transmite.
  - final (`pronto`=1) → inicial, or → espera_intervalo under the macro with `continuo`=1.
  - espera_intervalo → preparacao when the counter reaches `INTERVALO_CICLOS`-1; → inicial if `continuo` drops.
  - erro (`erro`=1) → preparacao on `mensurar`; stays in erro otherwise.
- Cycle counter:
  - one counter of width `$clog2(max(TIMEOUT_CICLOS, INTERVALO_CICLOS))`;
  - cleared on every state change, increments only in aguarda_medida and espera_intervalo;
  - saturates, never wraps.
- Boundary rules:
  - `pronto_medida` in the same cycle as timeout: the measurement wins (→ transmite).
  - `mensurar` outside inicial/erro is ignored.
  - Status pulses arriving in non-waiting states are ignored.
  - `reset` mid-operation → inicial on the next edge. The digit counter is not touched until the next preparacao.

## Timing
- Reset values:
  - state inicial;
  - `zera`, `medir`, `partida_serial`, `conta_ascii`, `pronto`, `erro` all 0;
  - `db_estado`=0;
  - counter 0.
- `mensurar` sampled at edge k:
  - `zera` high during cycle k+1;
  - `medir` high during cycle k+2;
  - aguarda_medida from k+3.
- `pronto_medida` at edge m: `partida_serial` high during cycle m+1.
- Between characters: `pronto_transmissao` at edge t → `conta_ascii` at t+1 → `partida_serial` at t+2.
- Frame = exactly 4 `partida_serial` pulses and 3 `conta_ascii` pulses, then `pronto` for one cycle.
- Timeout: erro entered exactly `TIMEOUT_CICLOS` cycles after entering aguarda_medida.

## Configuration
- `TRENA_UC_CONTINUO_EN` defined:
  - espera_intervalo exists;
  - with `continuo`=1, after final the block waits `INTERVALO_CICLOS` cycles, then re-enters preparacao without `mensurar`.
- Undefined:
  - state 8 is not generated and `continuo` is ignored;
  - final always → inicial;
  - the counter is sized by `TIMEOUT_CICLOS` alone.

## Structure
- Shared package `trena_pkg` holds:
  - the 4-bit state code constants, shared with the 7-segment debug decoder;
  - the separator ASCII constant.
- One sub-module, `contador_ciclos`:
  - parametric width; synchronous clear, enable, saturation;
  - `fim` output when the count equals a limit input.
- The FSM selects the limit per state.

## Test plan
Bench parameters: `TIMEOUT_CICLOS`=20, `INTERVALO_CICLOS`=10.
- Reset held 3 cycles mid-transmission → next cycle `db_estado`=0, all outputs 0.
- `mensurar` pulse, `pronto_medida` 5 cycles after `medir`, each `pronto_transmissao` 8 cycles after `partida_serial`, `fim_serial` high on the 4th character → 1 `zera`, 1 `medir`, 4 `partida_serial`, 3 `conta_ascii`, 1 `pronto`, final→inicial.
- No `pronto_medida` → `erro`=1 exactly 20 cycles after entering aguarda_medida. A later `mensurar` → preparacao, `erro`=0.
- `pronto_medida` on the cycle the counter reaches 19 → transmite, `erro` stays 0.
- Macro defined, `continuo`=1 → a second `zera` exactly 11 cycles after `pronto`. With `continuo` dropped during espera_intervalo → inicial, no further `medir`.
- `mensurar` pulses during aguarda_transmissao → no effect on the pulse counts.

Source files
------------

// File: rtl/trena_pkg.sv
// Shared definitions for the tape-measure control path: state codes (also used by the
// 7-segment debug decoder), the frame separator character and a small sizing helper.
package trena_pkg;

  localparam logic [3:0] EST_INICIAL             = 4'h0;
  localparam logic [3:0] EST_PREPARACAO          = 4'h1;
  localparam logic [3:0] EST_INICIA_MEDIDA       = 4'h2;
  localparam logic [3:0] EST_AGUARDA_MEDIDA      = 4'h3;
  localparam logic [3:0] EST_TRANSMITE           = 4'h4;
  localparam logic [3:0] EST_AGUARDA_TRANSMISSAO = 4'h5;
  localparam logic [3:0] EST_PROXIMO             = 4'h6;
  localparam logic [3:0] EST_FINAL               = 4'h7;
  localparam logic [3:0] EST_ESPERA_INTERVALO    = 4'h8;
  localparam logic [3:0] EST_ERRO                = 4'hE;

  typedef enum logic [3:0] {
    Inicial            = EST_INICIAL,
    Preparacao         = EST_PREPARACAO,
    IniciaMedida       = EST_INICIA_MEDIDA,
    AguardaMedida      = EST_AGUARDA_MEDIDA,
    Transmite          = EST_TRANSMITE,
    AguardaTransmissao = EST_AGUARDA_TRANSMISSAO,
    Proximo            = EST_PROXIMO,
    Final              = EST_FINAL,
    EsperaIntervalo    = EST_ESPERA_INTERVALO,
    Erro               = EST_ERRO
  } estado_t;

  // Fourth character of every frame, after the three BCD digits.
  localparam logic [7:0] ASCII_SEPARADOR = 8'h23;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trena_uc_contador_ciclos.sv
// Saturating cycle counter with synchronous clear/enable and an equality flag against a
// run-time limit.
module contador_ciclos #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_limpa,
  input  logic         i_conta,
  input  logic [W-1:0] i_limite,
  output logic         o_fim
);

  logic [W-1:0] r_valor;

  always_ff @(posedge clock) begin
    if (reset || i_limpa) begin
      r_valor <= '0;
    end else if (i_conta && (r_valor != {W{1'b1}})) begin
      r_valor <= r_valor + 1'b1;
    end
  end

  assign o_fim = (r_valor == i_limite);

endmodule

// File: rtl/trena_uc.sv
// Control unit for the ultrasonic tape measure: clear, measure (with timeout), send frame.
// Optional continuous mode is enabled by defining TRENA_UC_CONTINUO_EN.
module trena_uc
  import trena_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS   = 2500000,
  parameter int unsigned INTERVALO_CICLOS = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       continuo,
  input  logic       pronto_medida,
  input  logic       pronto_transmissao,
  input  logic       fim_serial,
  output logic       zera,
  output logic       medir,
  output logic       partida_serial,
  output logic       conta_ascii,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

`ifdef TRENA_UC_CONTINUO_EN
  localparam int unsigned LimiteMax = max_u(TIMEOUT_CICLOS, INTERVALO_CICLOS);
`else
  localparam int unsigned LimiteMax = TIMEOUT_CICLOS;
`endif
  localparam int unsigned W = (LimiteMax > 1) ? $clog2(LimiteMax) : 1;

  estado_t      r_estado;
  estado_t      w_estado_prox;
  logic         w_troca;
  logic         w_conta;
  logic         w_fim;
  logic [W-1:0] w_limite;

`ifndef TRENA_UC_CONTINUO_EN
  logic w_unused_continuo;
  assign w_unused_continuo = continuo;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= Inicial;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    unique case (r_estado)
      Inicial:            if (mensurar) w_estado_prox = Preparacao;
      Preparacao:         w_estado_prox = IniciaMedida;
      IniciaMedida:       w_estado_prox = AguardaMedida;
      // A measurement arriving on the timeout cycle still wins.
      AguardaMedida: begin
        if (pronto_medida) w_estado_prox = Transmite;
        else if (w_fim)    w_estado_prox = Erro;
      end
      Transmite:          w_estado_prox = AguardaTransmissao;
      AguardaTransmissao: begin
        if (pronto_transmissao) w_estado_prox = fim_serial ? Final : Proximo;
      end
      Proximo:            w_estado_prox = Transmite;
`ifdef TRENA_UC_CONTINUO_EN
      Final:              w_estado_prox = continuo ? EsperaIntervalo : Inicial;
      EsperaIntervalo: begin
        if (!continuo)  w_estado_prox = Inicial;
        else if (w_fim) w_estado_prox = Preparacao;
      end
`else
      Final:              w_estado_prox = Inicial;
`endif
      Erro:               if (mensurar) w_estado_prox = Preparacao;
      default:            w_estado_prox = Inicial;
    endcase
  end

  always_comb begin
    zera           = 1'b0;
    medir          = 1'b0;
    partida_serial = 1'b0;
    conta_ascii    = 1'b0;
    pronto         = 1'b0;
    erro           = 1'b0;
    unique case (r_estado)
      Preparacao:   zera           = 1'b1;
      IniciaMedida: medir          = 1'b1;
      Transmite:    partida_serial = 1'b1;
      Proximo:      conta_ascii    = 1'b1;
      Final:        pronto         = 1'b1;
      Erro:         erro           = 1'b1;
      default:      ;
    endcase
  end

  assign db_estado = r_estado;

  // Counter restarts on every state change so each waiting state sees a fresh count.
  assign w_troca = (w_estado_prox != r_estado);

  always_comb begin
    w_limite = W'(TIMEOUT_CICLOS - 1);
    w_conta  = (r_estado == AguardaMedida);
`ifdef TRENA_UC_CONTINUO_EN
    if (r_estado == EsperaIntervalo) begin
      w_limite = W'(INTERVALO_CICLOS - 1);
      w_conta  = 1'b1;
    end
`endif
  end

  contador_ciclos #(
    .W (W)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .i_limpa  (w_troca),
    .i_conta  (w_conta),
    .i_limite (w_limite),
    .o_fim    (w_fim)
  );

endmodule
